pos_sweep_eval: RTL and testbench
=================================

Name: pos_sweep_eval

Overview:
Programmable N-input product-of-sums function evaluator, successor to the fixed 3-input gate-level POS equation circuits.
- Function defined by a maxterm mask, not hard-wired gates.
- Two uses: single registered evaluation via valid handshake; automatic sweep of all 2^N_IN input combinations that captures the full truth table and ones count.
- Serves as a self-checking truth-table generator beside the lab's combinational equation circuits.

Parameters:
- N_IN, 3, number of function inputs; legal range 1..6.
- N_TERMS, 2**N_IN, derived (localparam), number of maxterms / truth-table rows.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- maxterm_mask  in  N_TERMS  bit k=1 means F=0 at input combination k (maxterm k present).
- start  in  1  begin sweep; sampled only in IDLE.
- eval_valid  in  1  single-evaluation request.
- eval_vec  in  N_IN  input combination for single evaluation; bit N_IN-1 = MSB (A).
- eval_rdy  out  1  equals ~busy (combinational from state).
- y_valid  out  1  one-cycle pulse; y is valid.
- y  out  1  single-evaluation result.
- busy  out  1  high in SWEEP and DONE.
- done  out  1  one-cycle pulse at sweep end.
- cur_in  out  N_IN  combination applied in the most recent sweep cycle.
- cur_y  out  1  F(cur_in).
- tt_out  out  N_TERMS  captured truth table; bit k = F(k).
- ones_cnt  out  N_IN+1  number of combinations with F=1.

Behaviour:
- Reset (async on rst_n low): state IDLE; busy, done, y_valid, y, cur_in, cur_y, tt_out, ones_cnt, idx, mask_q all 0.
- F(v) = AND over k of (mask[k] ? (v != k) : 1). This is a pure POS: each present maxterm contributes one sum term.
- States:
  - IDLE: start=1 at edge E0 -> latch mask_q <= maxterm_mask; clear tt_out and ones_cnt; idx <= 0; go to SWEEP.
  - SWEEP: at each edge E1..E_N_TERMS: cur_in <= idx; cur_y <= F_q(idx); tt_out[idx] <= F_q(idx); ones_cnt += F_q(idx); idx++. At idx == N_TERMS-1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Timing: done high in the cycle after E_N_TERMS. Start-to-done is N_TERMS+1 edges. With start held high, back-to-back sweeps repeat every N_TERMS+2 cycles.
- Mask latched at start; maxterm_mask changes mid-sweep have no effect.
- start while busy: ignored, not queued.
- Single evaluation:
  - Accepted only when eval_valid && eval_rdy (IDLE).
  - Latency 1: next cycle y_valid=1 and y=F(maxterm_mask, eval_vec), using the live mask.
  - eval_valid while busy: dropped; y_valid stays 0.
- Simultaneous start and eval_valid in IDLE: both accepted. The eval result appears in the first SWEEP cycle; the sweep proceeds unaffected.
- tt_out, ones_cnt, cur_in, cur_y hold their values after DONE until the next start.
- ones_cnt range 0..N_TERMS; width N_IN+1, no overflow.
- Reset mid-sweep: immediate return to IDLE, all outputs cleared, no done pulse. The next start behaves as after power-up.

Decomposition:
- Shared package pos_pkg holds:
  - state enum {IDLE, SWEEP, DONE};
  - function for max legal N_IN (6);
  - width helper for ones_cnt.
- Sub-module pos_term_eval (combinational, parameter N_IN): inputs mask and vec, output f. Instantiated twice: sweep path using mask_q, eval path using live mask.

Test Plan:
- N_IN=3, mask=8'b0000_0111, start pulse -> done exactly 9 edges after the start edge; tt_out=8'b1111_1000; ones_cnt=5; cur_in sequences 0..7.
- Same mask, no sweep: eval_vec=3'b011 -> next cycle y_valid=1, y=1. eval_vec=3'b010 -> y=0.
- mask=8'h00 sweep -> tt_out=8'hFF, ones_cnt=8. mask=8'hFF sweep -> tt_out=8'h00, ones_cnt=0.
- Change mask to 8'hFF at idx=3 during a sweep started with 8'h07 -> result still tt_out=8'hF8. eval_valid during the sweep -> eval_rdy=0, no y_valid.
- Drive rst_n low at idx=4 -> all outputs 0 immediately, no done pulse. Restart -> correct 8'hF8 result.
- start held high for 30 cycles -> done pulses every 10 cycles. N_IN=1, mask=2'b01 -> tt_out=2'b10, ones_cnt=1, done 3 edges after start.

Source files
------------

// File: rtl/pos_pkg.sv
// Shared types and helpers for the programmable product-of-sums evaluator.
package pos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int max_n_in();
    return 6;
  endfunction

  // ones_cnt must reach 2**n, which needs one bit more than the input vector.
  function automatic int cnt_width(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/pos_term_eval.sv
// Combinational POS evaluation: F is the AND of one sum term per present maxterm.
module pos_term_eval #(
  parameter  int N_IN    = 3,
  localparam int N_TERMS = 2 ** N_IN
) (
  input  logic [N_TERMS-1:0] mask,
  input  logic [N_IN-1:0]    vec,
  output logic               f
);

  // A present maxterm k forces F low only on its own combination.
  always_comb begin
    f = 1'b1;
    for (int k = 0; k < N_TERMS; k++) begin
      if (mask[k] && (vec == N_IN'(k))) begin
        f = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pos_sweep_eval.sv
// Programmable N-input POS evaluator with single registered evaluation and a
// full truth-table sweep that captures the table and its ones count.
module pos_sweep_eval
  import pos_pkg::*;
#(
  parameter  int N_IN    = 3,
  localparam int N_TERMS = 2 ** N_IN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_TERMS-1:0] maxterm_mask,
  input  logic               start,
  input  logic               eval_valid,
  input  logic [N_IN-1:0]    eval_vec,
  output logic               eval_rdy,
  output logic               y_valid,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic [N_IN-1:0]    cur_in,
  output logic               cur_y,
  output logic [N_TERMS-1:0] tt_out,
  output logic [N_IN:0]      ones_cnt
);

  localparam int CW = cnt_width(N_IN);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(N_TERMS - 1);

  state_e             state_q;
  logic [N_TERMS-1:0] mask_q;
  logic [N_IN-1:0]    idx_q;
  logic [N_TERMS-1:0] tt_q;
  logic [CW-1:0]      ones_q;
  logic [CW-1:0]      ones_d;
  logic [N_IN-1:0]    cur_in_q;
  logic               cur_y_q;
  logic               y_q;
  logic               y_valid_q;
  logic               done_q;
  logic               f_sweep;
  logic               f_eval;

  // Sweep path sees the mask frozen at start; eval path sees the live mask.
  pos_term_eval #(.N_IN(N_IN)) u_sweep_term (
    .mask (mask_q),
    .vec  (idx_q),
    .f    (f_sweep)
  );

  pos_term_eval #(.N_IN(N_IN)) u_eval_term (
    .mask (maxterm_mask),
    .vec  (eval_vec),
    .f    (f_eval)
  );

  assign ones_d = ones_q + CW'(f_sweep);

  // done is registered while leaving DONE, so it lands one edge after DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      idx_q     <= '0;
      tt_q      <= '0;
      ones_q    <= '0;
      cur_in_q  <= '0;
      cur_y_q   <= 1'b0;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      y_valid_q <= 1'b0;
      if (eval_valid && (state_q == IDLE)) begin
        y_valid_q <= 1'b1;
        y_q       <= f_eval;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q  <= maxterm_mask;
            tt_q    <= '0;
            ones_q  <= '0;
            idx_q   <= '0;
            state_q <= SWEEP;
          end
        end
        SWEEP: begin
          cur_in_q    <= idx_q;
          cur_y_q     <= f_sweep;
          tt_q[idx_q] <= f_sweep;
          ones_q      <= ones_d;
          idx_q       <= idx_q + N_IN'(1);
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eval_rdy = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign y_valid  = y_valid_q;
  assign y        = y_q;
  assign done     = done_q;
  assign cur_in   = cur_in_q;
  assign cur_y    = cur_y_q;
  assign tt_out   = tt_q;
  assign ones_cnt = ones_q;

endmodule

// File: tb/tb_pos_sweep_eval.sv
// Directed bench for pos_sweep_eval (N_IN=3 and N_IN=1) with a queue scoreboard
// of expected eval results and sweep results.
module tb_pos_sweep_eval;

  typedef struct packed {
    logic [7:0] tt;
    logic [3:0] ones;
  } sweepExp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] mask3;
  logic       start3, evalValid3;
  logic [2:0] evalVec3;
  logic       evalRdy3, yValid3, y3, busy3, done3, curY3;
  logic [2:0] curIn3;
  logic [7:0] tt3;
  logic [3:0] ones3;

  logic [1:0] mask1;
  logic       start1, evalValid1;
  logic [0:0] evalVec1;
  logic       evalRdy1, yValid1, y1, busy1, done1, curY1;
  logic [0:0] curIn1;
  logic [1:0] tt1;
  logic [1:0] ones1;

  int checkCount = 0;
  int failCount  = 0;

  logic      yQ[$];
  sweepExp_t sweepQ[$];

  always #5 clk = ~clk;

  pos_sweep_eval #(.N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .maxterm_mask(mask3), .start(start3),
    .eval_valid(evalValid3), .eval_vec(evalVec3), .eval_rdy(evalRdy3),
    .y_valid(yValid3), .y(y3), .busy(busy3), .done(done3),
    .cur_in(curIn3), .cur_y(curY3), .tt_out(tt3), .ones_cnt(ones3)
  );

  pos_sweep_eval #(.N_IN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .maxterm_mask(mask1), .start(start1),
    .eval_valid(evalValid1), .eval_vec(evalVec1), .eval_rdy(evalRdy1),
    .y_valid(yValid1), .y(y1), .busy(busy1), .done(done1),
    .cur_in(curIn1), .cur_y(curY1), .tt_out(tt1), .ones_cnt(ones1)
  );

  function automatic logic modelF(input logic [7:0] m, input int v, input int nTerms);
    logic f;
    f = 1'b1;
    for (int k = 0; k < nTerms; k++) begin
      if (m[k] && (v == k)) f = 1'b0;
    end
    return f;
  endfunction

  function automatic sweepExp_t modelSweep(input logic [7:0] m);
    sweepExp_t e;
    e.tt   = '0;
    e.ones = '0;
    for (int k = 0; k < 8; k++) begin
      e.tt[k] = modelF(m, k, 8);
      e.ones  = e.ones + {3'b000, e.tt[k]};
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"},     busy3,    0);
    checkOutput({tag, "_done"},     done3,    0);
    checkOutput({tag, "_y_valid"},  yValid3,  0);
    checkOutput({tag, "_y"},        y3,       0);
    checkOutput({tag, "_cur_in"},   curIn3,   0);
    checkOutput({tag, "_cur_y"},    curY3,    0);
    checkOutput({tag, "_tt_out"},   tt3,      0);
    checkOutput({tag, "_ones_cnt"}, ones3,    0);
    checkOutput({tag, "_eval_rdy"}, evalRdy3, 1);
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [2:0] v);
    logic expY;
    mask3      = m;
    evalVec3   = v;
    evalValid3 = 1'b1;
    yQ.push_back(modelF(m, int'(v), 8));
    tick();
    evalValid3 = 1'b0;
    checkOutput($sformatf("eval_y_valid_v%0d", v), yValid3, 1);
    expY = yQ.pop_front();
    checkOutput($sformatf("eval_y_v%0d", v), y3, expY);
    tick();
    checkOutput($sformatf("eval_y_valid_drop_v%0d", v), yValid3, 0);
  endtask

  // changeAt/resetAt name the sweep edge after which the disturbance is applied (0 = none).
  task automatic runSweep(input logic [7:0] m, input bit evalAtStart,
                          input int changeAt, input int resetAt);
    sweepExp_t e;
    logic      expY;
    sweepQ.push_back(modelSweep(m));
    mask3  = m;
    start3 = 1'b1;
    if (evalAtStart) begin
      evalValid3 = 1'b1;
      evalVec3   = 3'd1;
      yQ.push_back(modelF(m, 1, 8));
    end
    tick();
    start3     = 1'b0;
    evalValid3 = 1'b0;
    checkOutput("sweep_busy", busy3, 1);
    if (evalAtStart) begin
      checkOutput("sweep_start_y_valid", yValid3, 1);
      expY = yQ.pop_front();
      checkOutput("sweep_start_y", y3, expY);
    end else begin
      checkOutput("sweep_start_y_valid", yValid3, 0);
    end
    for (int edgeN = 1; edgeN <= 9; edgeN++) begin
      tick();
      if (edgeN <= 8) begin
        checkOutput($sformatf("cur_in_e%0d", edgeN), curIn3, edgeN - 1);
        checkOutput($sformatf("cur_y_e%0d", edgeN), curY3, modelF(m, edgeN - 1, 8));
      end
      checkOutput($sformatf("done_e%0d", edgeN), done3, (edgeN == 9) ? 1 : 0);
      checkOutput($sformatf("y_valid_e%0d", edgeN), yValid3, 0);
      if (edgeN == changeAt) begin
        mask3      = 8'hFF;
        evalValid3 = 1'b1;
        evalVec3   = 3'd3;
        checkOutput("busy_eval_rdy", evalRdy3, 0);
      end
      if (edgeN == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        void'(sweepQ.pop_front());
        for (int i = 0; i < 3; i++) begin
          tick();
          checkOutput($sformatf("midreset_done_%0d", i), done3, 0);
        end
        rst_n = 1'b1;
        return;
      end
    end
    evalValid3 = 1'b0;
    e = sweepQ.pop_front();
    checkOutput("sweep_tt_out", tt3, e.tt);
    checkOutput("sweep_ones_cnt", ones3, e.ones);
    checkOutput("sweep_busy_after", busy3, 0);
    checkOutput("sweep_eval_rdy_after", evalRdy3, 1);
    tick();
    checkOutput("done_pulse_width", done3, 0);
    checkOutput("tt_out_hold", tt3, e.tt);
  endtask

  initial begin
    logic [29:0] obsDone, expDone;
    rst_n      = 1'b0;
    mask3      = 8'h00;
    start3     = 1'b0;
    evalValid3 = 1'b0;
    evalVec3   = 3'd0;
    mask1      = 2'b00;
    start1     = 1'b0;
    evalValid1 = 1'b0;
    evalVec1   = 1'b0;
    #1;
    checkResetState("por");
    checkOutput("por_dut1_tt_out", tt1, 0);
    checkOutput("por_dut1_ones_cnt", ones1, 0);
    checkOutput("por_dut1_busy", busy1, 0);
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus(8'h07, 3'b011);
    applyStimulus(8'h07, 3'b010);

    runSweep(8'h07, 1'b0, 0, 0);
    runSweep(8'h00, 1'b0, 0, 0);
    runSweep(8'hFF, 1'b0, 0, 0);
    runSweep(8'h07, 1'b0, 3, 0);
    runSweep(8'h07, 1'b0, 0, 4);
    runSweep(8'h07, 1'b0, 0, 0);
    runSweep(8'h07, 1'b1, 0, 0);

    mask3  = 8'h07;
    start3 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      obsDone[i] = done3;
      expDone[i] = ((i % 10) == 9);
    end
    start3 = 1'b0;
    checkOutput("held_start_done_pattern", obsDone, expDone);
    checkOutput("held_start_tt_out", tt3, 8'hF8);
    checkOutput("held_start_ones_cnt", ones3, 5);

    mask1  = 2'b01;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int edgeN = 1; edgeN <= 3; edgeN++) begin
      tick();
      if (edgeN <= 2) checkOutput($sformatf("n1_cur_in_e%0d", edgeN), curIn1, edgeN - 1);
      checkOutput($sformatf("n1_done_e%0d", edgeN), done1, (edgeN == 3) ? 1 : 0);
    end
    checkOutput("n1_tt_out", tt1, 2'b10);
    checkOutput("n1_ones_cnt", ones1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
